// File: rtl/counter_pkg.sv
// Shared types for the programmable counter: terminal modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_STOP   = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler for the programmable counter: emits one tick on every
// PRESCALE-th cycle in which i_enable is high. Holds while i_enable is low;
// i_clear restarts the phase. Only used when COUNTER_PRESCALE_EN is defined.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  // Tick fires on the enabled cycle that completes a PRESCALE-long phase.
  assign o_tick = i_enable && (r_cnt == LAST);

  // Phase counter: clear has priority, advances only on enabled cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (o_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Loadable up/down counter with programmable limit, terminal-count mode
// (WRAP / STOP / RELOAD), sticky overflow and a one-cycle done pulse.
// Optional: define COUNTER_PRESCALE_EN to step only on every PRESCALE-th
// enabled RUN cycle; without it every enabled RUN cycle is a step.
//
// Control handshake: start is a single-cycle command with no back-pressure;
// it is accepted on any rising edge where reset is low and overrides all
// counting in that cycle. enable qualifies stepping only while busy is high.
module prog_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOAD_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LOAD_W-1:0] load_value,
  input  logic              enable,
  input  logic              up_down,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count,
  output logic              overflow,
  output logic              done,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Reject illegal parameterisations at elaboration time.
  if (WIDTH < 2 || LOAD_W < 1 || LOAD_W > WIDTH || PRESCALE < 1) begin : g_bad_param
    $error("prog_counter: illegal WIDTH/LOAD_W/PRESCALE");
  end

  state_e            r_state;
  logic [WIDTH-1:0]  r_count;
  logic              r_overflow;
  logic              r_done;
  logic [LOAD_W-1:0] r_reload;

  logic              w_run;
  logic              w_tick;
  logic              w_at_term;
  logic              w_term;
  logic              w_step;
  mode_e             w_mode;

  assign w_run  = (r_state == ST_RUN);
  assign w_mode = mode_e'(mode);

`ifdef COUNTER_PRESCALE_EN
  logic w_pre_clear;

  // Prescaler restarts its phase on start and after every terminal event.
  assign w_pre_clear = start || w_term;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (w_pre_clear),
    .i_enable (w_run && enable),
    .o_tick   (w_tick)
  );
`else
  assign w_tick = w_run && enable;
`endif

  // A step is an enabled (and prescaled) RUN cycle; terminal if at the bound.
  assign w_step    = w_run && w_tick;
  assign w_at_term = up_down ? (r_count >= limit) : (r_count == '0);
  assign w_term    = w_step && w_at_term;

  // Counter, flags and IDLE/RUN/HALT state; reset beats start beats stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_reload   <= '0;
    end else if (start) begin
      r_state    <= ST_RUN;
      r_count    <= WIDTH'(load_value);
      r_reload   <= load_value;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_term) begin
        r_overflow <= 1'b1;
        r_done     <= 1'b1;
        case (w_mode)
          MODE_STOP:   r_state <= ST_HALT;
          MODE_RELOAD: r_count <= WIDTH'(r_reload);
          default:     r_count <= up_down ? '0 : limit;
        endcase
      end else if (w_step) begin
        r_count <= up_down ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
      end
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign done      = r_done;
  assign busy      = w_run;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_prog_counter;
  import counter_pkg::*;

  localparam int WIDTH    = 8;
  localparam int LOAD_W   = 4;
  localparam int PRESCALE = 4;
  localparam int MAXV     = 1 << WIDTH;
`ifdef COUNTER_PRESCALE_EN
  localparam int P_EFF = PRESCALE;
`else
  localparam int P_EFF = 1;
`endif

  // Clock / reset block
  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [LOAD_W-1:0] load_value;
  logic              enable;
  logic              up_down;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  count;
  logic              overflow;
  logic              done;
  logic              busy;
  logic [1:0]        dbg_state;

  always #5 clock = ~clock;

  prog_counter #(
    .WIDTH    (WIDTH),
    .LOAD_W   (LOAD_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_value (load_value),
    .enable     (enable),
    .up_down    (up_down),
    .mode       (mode),
    .limit      (limit),
    .count      (count),
    .overflow   (overflow),
    .done       (done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Behavioural reference model
  int m_count, m_reload, m_pre;
  bit m_ovf, m_done, m_run, m_halt;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_terminal(input bit up);
    m_ovf  = 1;
    m_done = 1;
    case (int'(mode))
      1: begin m_run = 0; m_halt = 1; end
      2: m_count = m_reload;
      default: m_count = up ? 0 : int'(limit);
    endcase
  endfunction

  function automatic void model_edge();
    if (reset) begin
      m_count = 0; m_reload = 0; m_ovf = 0; m_done = 0;
      m_run = 0; m_halt = 0; m_pre = 0;
    end else if (start) begin
      m_count = int'(load_value); m_reload = int'(load_value);
      m_ovf = 0; m_done = 0; m_run = 1; m_halt = 0; m_pre = 0;
    end else begin
      m_done = 0;
      if (m_run && enable) begin
        m_pre++;
        if (m_pre == P_EFF) begin
          m_pre = 0;
          if (up_down) begin
            if (m_count >= int'(limit)) model_terminal(1'b1);
            else m_count = (m_count + 1) % MAXV;
          end else begin
            if (m_count == 0) model_terminal(1'b0);
            else m_count = m_count - 1;
          end
        end
      end
    end
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: advance one edge with current inputs, then compare everything.
  task automatic step();
    logic [1:0] exp_state;
    model_edge();
    @(posedge clock);
    #1;
    exp_state = m_halt ? ST_HALT : (m_run ? ST_RUN : ST_IDLE);
    chk("count",    32'(count),     32'(m_count));
    chk("overflow", 32'(overflow),  32'(m_ovf));
    chk("done",     32'(done),      32'(m_done));
    chk("busy",     32'(busy),      32'(m_run));
    chk("state",    32'(dbg_state), 32'(exp_state));
  endtask

  task automatic do_start(input logic [LOAD_W-1:0] lv);
    start = 1'b1; load_value = lv;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_wrap [4];
    logic [7:0] exp_rel  [6];
    exp_wrap = '{8'h10, 8'h11, 8'h12, 8'h00};
    exp_rel  = '{8'h06, 8'h07, 8'h05, 8'h06, 8'h07, 8'h05};

    reset = 1'b1; start = 1'b0; load_value = '0; enable = 1'b0;
    up_down = 1'b1; mode = 2'd0; limit = '0;
    step();
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    step();
    reset = 1'b0;

    // IDLE ignores enable
    enable = 1'b1;
    step();
    chk("idle_hold", 32'(count), 32'h0);

    // WRAP, up, limit 12, load F
    mode = 2'd0; up_down = 1'b1; limit = 8'h12; enable = 1'b0;
    do_start(4'hF);
    chk("wrap_load", 32'(count), 32'h0F);
    enable = 1'b1;
    for (int i = 0; i < 4 * P_EFF; i++) begin
      step();
`ifndef COUNTER_PRESCALE_EN
      chk("wrap_seq",  32'(count), 32'(exp_wrap[i]));
      chk("wrap_done", 32'(done),  32'(i == 3));
`endif
    end
    step();
    chk("wrap_ovf_sticky", 32'(overflow), 32'h1);

    // STOP, down, load 3
    mode = 2'd1; up_down = 1'b0; enable = 1'b0;
    do_start(4'h3);
    enable = 1'b1;
    for (int i = 0; i < 4 * P_EFF; i++) step();
    chk("stop_count", 32'(count),     32'h0);
    chk("stop_halt",  32'(dbg_state), 32'(ST_HALT));
    chk("stop_busy",  32'(busy),      32'h0);
    step();
    chk("halt_done_clear", 32'(done), 32'h0);
    do_start(4'h5);
    chk("restart_count", 32'(count),    32'h05);
    chk("restart_ovf",   32'(overflow), 32'h0);

    // RELOAD, up, limit 7, load 5
    mode = 2'd2; up_down = 1'b1; limit = 8'h07; enable = 1'b0;
    do_start(4'h5);
    enable = 1'b1;
    for (int i = 0; i < 6 * P_EFF; i++) begin
      step();
`ifndef COUNTER_PRESCALE_EN
      chk("reload_seq",  32'(count), 32'(exp_rel[i]));
      chk("reload_done", 32'(done),  32'(i == 2 || i == 5));
`endif
    end

    // Load above limit terminates on first enabled step; enable toggling
    mode = 2'd0; limit = 8'h0A; enable = 1'b0;
    do_start(4'hF);
    enable = 1'b1;
    for (int i = 0; i < P_EFF; i++) step();
    chk("above_limit_wrap", 32'(count), 32'h00);
    for (int i = 0; i < 4; i++) begin
      enable = (i % 2 == 1);
      step();
    end
`ifndef COUNTER_PRESCALE_EN
    chk("enable_toggle", 32'(count), 32'h02);
`endif

    // Reset with start mid-run
    limit = 8'h20; enable = 1'b0;
    do_start(4'h9);
    reset = 1'b1; start = 1'b1;
    step();
    chk("rst_over_start_count", 32'(count),     32'h0);
    chk("rst_over_start_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0; start = 1'b0;

`ifdef COUNTER_PRESCALE_EN
    // Prescaled counting: one step per PRESCALE enabled cycles
    mode = 2'd0; up_down = 1'b1; limit = 8'hFF;
    do_start(4'h0);
    enable = 1'b1;
    for (int i = 1; i <= 2 * PRESCALE; i++) begin
      step();
      chk("prescale_count", 32'(count), 32'(i / PRESCALE));
    end
    enable = 1'b0; step(); step();
    enable = 1'b1;
    for (int i = 0; i < PRESCALE; i++) step();
    chk("prescale_pause", 32'(count), 32'h03);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 19) == 0);
      load_value = LOAD_W'($urandom_range(0, (1 << LOAD_W) - 1));
      enable     = ($urandom_range(0, 3) != 0);
      up_down    = 1'($urandom_range(0, 1));
      mode       = 2'($urandom_range(0, 3));
      limit      = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, MAXV - 1))
                                               : WIDTH'($urandom_range(0, 20));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
